// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and helpers for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_SUMA    = 3'b000;
  localparam logic [2:0] OP_SHIFT_D = 3'b001;
  localparam logic [2:0] OP_RESTA   = 3'b010;
  localparam logic [2:0] OP_SHIFT_I = 3'b011;
  localparam logic [2:0] OP_MUL     = 3'b100;
  localparam logic [2:0] OP_AND     = 3'b101;
  localparam logic [2:0] OP_OR      = 3'b110;
  localparam logic [2:0] OP_XOR     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHIFT_D) || (op == OP_SHIFT_I);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Start handshake, operands and registered result/flags of alu_seq.
interface alu_seq_if #(
  parameter int N = 16
) ();
  logic         i_valid;
  logic [2:0]   i_control;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic         o_ready;
  logic         o_done;
  logic [N-1:0] q;
  logic         o_mayor;
  logic         o_zero;
  logic         o_carry;

  modport master (
    output i_valid, i_control, i_a, i_b,
    input  o_ready, o_done, q, o_mayor, o_zero, o_carry
  );

  modport slave (
    input  i_valid, i_control, i_a, i_b,
    output o_ready, o_done, q, o_mayor, o_zero, o_carry
  );
endinterface

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU ops with carry/borrow; shift/mul codes pass A through
// so a zero-length shift resolves here without entering BUSY.
module alu_seq_comb
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [2:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_y,
  output logic         o_carry,
  output logic         o_mayor
);
  logic [N:0] w_sum;
  logic [N:0] w_diff;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
  assign o_mayor = (i_a > i_b);

  always_comb begin
    o_y     = i_a;
    o_carry = 1'b0;
    case (i_op)
      OP_SUMA:  begin o_y = w_sum[N-1:0];  o_carry = w_sum[N];  end
      OP_RESTA: begin o_y = w_diff[N-1:0]; o_carry = w_diff[N]; end
      OP_AND:   o_y = i_a & i_b;
      OP_OR:    o_y = i_a | i_b;
      OP_XOR:   o_y = i_a ^ i_b;
      default:  o_y = i_a;
    endcase
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready start, single-cycle ops via alu_seq_comb,
// iterative 1-bit/cycle shifts and N-cycle shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_op;
  logic [N-1:0]   r_a, r_b, r_acc, r_q;
  logic [CW-1:0]  r_cnt;
  logic           r_mayor_p, r_mayor, r_zero, r_carry;

  logic           w_accept, w_iter_start, w_last, w_is_mul;
  logic [SW-1:0]  w_k;
  logic [N-1:0]   w_y, w_sh_nxt, w_acc_nxt, w_fin;
  logic           w_c, w_mayor, w_sh_out;

  alu_seq_comb #(.N(N)) u_comb (
    .i_op    (bus.i_control),
    .i_a     (bus.i_a),
    .i_b     (bus.i_b),
    .o_y     (w_y),
    .o_carry (w_c),
    .o_mayor (w_mayor)
  );

  assign w_k          = bus.i_b[SW-1:0];
  assign w_accept     = bus.i_valid && (r_state == ST_IDLE);
  assign w_iter_start = (bus.i_control == OP_MUL) ||
                        (is_shift(bus.i_control) && (w_k != '0));
  assign w_last       = (r_cnt == CW'(1));
  assign w_is_mul     = (r_op == OP_MUL);

  assign w_sh_nxt  = (r_op == OP_SHIFT_I) ? {r_a[N-2:0], 1'b0} : {1'b0, r_a[N-1:1]};
  assign w_sh_out  = (r_op == OP_SHIFT_I) ? r_a[N-1] : r_a[0];
  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
  assign w_fin     = w_is_mul ? w_acc_nxt : w_sh_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_iter_start ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result/flags only move on the edge entering DONE; BUSY keeps them held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_q       <= '0;
      r_mayor_p <= 1'b0;
      r_mayor   <= 1'b0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op      <= bus.i_control;
            r_mayor_p <= w_mayor;
            if (w_iter_start) begin
              r_a   <= bus.i_a;
              r_b   <= bus.i_b;
              r_acc <= '0;
              r_cnt <= (bus.i_control == OP_MUL) ? CW'(N) : CW'(w_k);
            end else begin
              r_q     <= w_y;
              r_carry <= w_c;
              r_mayor <= w_mayor;
              r_zero  <= (w_y == '0);
            end
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_is_mul) begin
            r_acc <= w_acc_nxt;
            r_a   <= {r_a[N-2:0], 1'b0};
            r_b   <= {1'b0, r_b[N-1:1]};
          end else begin
            r_a   <= w_sh_nxt;
          end
          if (w_last) begin
            r_q     <= w_fin;
            r_carry <= w_is_mul ? 1'b0 : w_sh_out;
            r_mayor <= r_mayor_p;
            r_zero  <= (w_fin == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready = (r_state == ST_IDLE);
  assign bus.o_done  = (r_state == ST_DONE);
  assign bus.q       = r_q;
  assign bus.o_mayor = r_mayor;
  assign bus.o_zero  = r_zero;
  assign bus.o_carry = r_carry;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against a latency/arithmetic model.
module tb_alu_seq;
  localparam int N = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.N(N)) bus ();

  alu_seq #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the outputs must be, derived from op rules and latency table
  bit           m_ready = 1'b1;
  bit           m_done  = 1'b0;
  int           m_left  = 0;
  logic [N-1:0] m_q     = '0;
  bit           m_c = 1'b0, m_z = 1'b0, m_m = 1'b0;
  logic [N-1:0] p_q;
  logic         p_c;
  bit           p_m;

  task automatic model_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] q, output logic c, output int lat);
    logic [31:0] wide;
    int k;
    k   = int'(b) % N;
    c   = 1'b0;
    lat = 1;
    case (op)
      3'd0: begin wide = 32'(a) + 32'(b); q = wide[N-1:0]; c = wide[N]; end
      3'd1: begin q = a >> k; if (k > 0) c = a[k-1]; lat = k + 1; end
      3'd2: begin q = a - b; c = (a < b); end
      3'd3: begin q = a << k; if (k > 0) c = a[N-k]; lat = k + 1; end
      3'd4: begin wide = 32'(a) * 32'(b); q = wide[N-1:0]; lat = N + 1; end
      3'd5: q = a & b;
      3'd6: q = a | b;
      default: q = a ^ b;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ready = 1'b1; m_done = 1'b0; m_left = 0;
      m_q = '0; m_c = 1'b0; m_z = 1'b0; m_m = 1'b0;
    end else begin
      if (m_done) begin
        m_done  = 1'b0;
        m_ready = 1'b1;
      end else if (m_ready && bus.i_valid) begin
        model_op(bus.i_control, bus.i_a, bus.i_b, p_q, p_c, m_left);
        p_m     = (bus.i_a > bus.i_b);
        m_ready = 1'b0;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_q = p_q; m_c = p_c; m_m = p_m; m_z = (p_q == '0);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ready", bus.o_ready, m_ready);
    chk("done",  bus.o_done,  m_done);
    chk("q",     bus.q,       m_q);
    chk("carry", bus.o_carry, m_c);
    chk("zero",  bus.o_zero,  m_z);
    chk("mayor", bus.o_mayor, m_m);
  end

  // Starts at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] eq, input logic ec,
                        input logic ez, input logic em, input int elat);
    int lat;
    bit seen;
    bus.i_valid = 1'b1; bus.i_control = op; bus.i_a = a; bus.i_b = b;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (bus.o_done) begin
        seen = 1'b1;
        bus.i_valid = 1'b0;
      end else begin
        bus.i_valid   = 1'($urandom_range(0, 1));
        bus.i_control = 3'($urandom);
        bus.i_a       = 16'($urandom);
        bus.i_b       = 16'($urandom);
        @(negedge clk);
        lat++;
      end
    end
    chk({name, "_seen"},  32'(seen), 32'd1);
    chk({name, "_lat"},   32'(lat), 32'(elat));
    chk({name, "_q"},     bus.q, eq);
    chk({name, "_carry"}, bus.o_carry, ec);
    chk({name, "_zero"},  bus.o_zero, ez);
    chk({name, "_mayor"}, bus.o_mayor, em);
    chk({name, "_model"}, m_q, eq);
    @(negedge clk);
  endtask

  initial begin
    int  dones;
    bit  prev, consec;
    bus.i_valid = 1'b1; bus.i_control = 3'b111; bus.i_a = 16'h0001; bus.i_b = 16'h0002;
    repeat (2) @(negedge clk);
    chk("rst_q",     bus.q, 16'h0000);
    chk("rst_ready", bus.o_ready, 1'b1);
    chk("rst_done",  bus.o_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_done", bus.o_done, 1'b1);
    chk("rel_q",    bus.q, 16'h0003);
    bus.i_valid = 1'b0;
    @(negedge clk);

    run_op("suma",   3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1, 1);
    run_op("resta",  3'b010, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1);
    run_op("shl4",   3'b011, 16'h8001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b1, 5);
    run_op("shr1",   3'b001, 16'h0003, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1, 2);
    run_op("shl0",   3'b011, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b1, 1);
    run_op("mul",    3'b100, 16'h0100, 16'h0101, 16'h0100, 1'b0, 1'b0, 1'b0, 17);

    bus.i_valid = 1'b1; bus.i_control = 3'b100; bus.i_a = 16'h0100; bus.i_b = 16'h0101;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", bus.o_ready, 1'b1);
    chk("arst_done",  bus.o_done, 1'b0);
    chk("arst_q",     bus.q, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("xor", 3'b111, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0, 1);

    dones = 0; prev = 1'b0; consec = 1'b0;
    bus.i_valid = 1'b1; bus.i_control = 3'b101;
    bus.i_a = 16'($urandom); bus.i_b = 16'($urandom);
    repeat (12) begin
      @(negedge clk);
      if (bus.o_done) dones++;
      if (prev && bus.o_done) consec = 1'b1;
      prev = bus.o_done;
      bus.i_control = (bus.i_control == 3'b101) ? 3'b110 : 3'b101;
      bus.i_a = 16'($urandom); bus.i_b = 16'($urandom);
    end
    bus.i_valid = 1'b0;
    chk("b2b_dones",  32'(dones), 32'd6);
    chk("b2b_consec", 32'(consec), 32'd0);
    repeat (2) @(negedge clk);

    repeat (400) begin
      bus.i_valid   = ($urandom_range(0, 2) != 0);
      bus.i_control = 3'($urandom);
      bus.i_a       = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      bus.i_b       = ($urandom_range(0, 7) == 0) ? bus.i_a  : 16'($urandom);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
